dmem_sized_ctrl: RTL
====================

// Module: dmem_sized_ctrl
// PURPOSE
//   Parametrised data memory with a request/response handshake, programmable access latency and
//   sized (byte/half/word) little-endian accesses with sign/zero extension.
//   Successor to the single-cycle word-only data memory; sits on the MEM stage and stalls the
//   pipeline via ready_o/valid_o. Storage is DEPTH_WORDS x 32-bit words with four byte lanes.
// PARAMETERS
//   DEPTH_WORDS  8   number of 32-bit words (byte capacity = 4*DEPTH_WORDS); power of two, >=2
//   ADDR_W       32  byte-address width
//   LATENCY      1   busy cycles per access (>=1); response arrives LATENCY+1 cycles after accept
// PORTS
//   clk_i       in   1       clock, all logic on rising edge
//   rst_i       in   1       synchronous, active-high reset
//   req_i       in   1       access request; accepted when req_i && ready_o
//   we_i        in   1       1 = store, 0 = load (sampled at accept)
//   size_i      in   2       00 byte, 01 half, 10 word, 11 reserved (sampled at accept)
//   unsigned_i  in   1       load: 1 = zero-extend, 0 = sign-extend (sampled at accept)
//   addr_i      in   ADDR_W  byte address (sampled at accept)
//   data_i      in   32      store data, right-justified (sampled at accept)
//   ready_o     out  1       controller idle, can accept a request this cycle
//   valid_o     out  1       one-cycle response pulse (loads and stores)
//   data_o      out  32      load result, valid when valid_o && !we; holds value otherwise
//   err_o       out  1       access error, qualified by valid_o
// BEHAVIOUR
//   - Reset: state IDLE, ready_o=1, valid_o=0, data_o=0, err_o=0, counter=0. Memory array
//     NOT cleared. Reset mid-access aborts it: pending store discarded, no valid_o pulse.
//   - FSM IDLE->BUSY on accept; request fields latched, counter loaded LATENCY-1.
//     BUSY: counter decrements; at counter==0 the access executes on that edge, valid_o
//     registered high for next cycle, FSM ->IDLE. ready_o = (state==IDLE).
//   - Accept in cycle N => valid_o high in cycle N+LATENCY+1 exactly. valid_o cycle is an IDLE
//     cycle, so a new request is accepted in the same cycle (back-to-back, one access per
//     LATENCY+1 cycles). req_i ignored while BUSY.
//   - Addressing: word index = addr[log2(DEPTH_WORDS)+1:2], lane = addr[1:0], little endian
//     (lane 0 = bits 7:0). Byte uses lane; half uses lanes {addr[1],0}+{0,1}; word all lanes.
//   - Store: only addressed lanes written; other lanes of the word unchanged. data_o unchanged.
//   - Load: selected bytes right-justified; upper bits = MSB of loaded value (signed) or 0.
//   - Store then load same address: load issued after store's valid_o sees the new data.
// CONFIGURATION
//   DMEM_ERR_EN defined: err_o=1 with valid_o for misaligned half (addr[0]=1), misaligned word
//     (addr[1:0]!=0), size_i=11, or addr >= 4*DEPTH_WORDS. Erroring store writes nothing;
//     erroring load returns data_o=0.
//   DMEM_ERR_EN undefined: err_o tied 0; half ignores addr[0], word ignores addr[1:0],
//     size_i=11 treated as word, upper address bits ignored (wraps modulo 4*DEPTH_WORDS).
// STRUCTURE
//   - Package dmem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, FSM state enum
//     (ST_IDLE, ST_BUSY), lane-mask helper constants.
//   - Sub-module dmem_lane_align (combinational): store lane-mask + data replication,
//     load lane extraction + sign/zero extension. Top holds FSM, counter, array, output regs.
// TESTING
//   1 LATENCY=1: store word 0x8765_4321 @0x04, load word @0x04 -> valid_o at N+2, data_o=0x87654321.
//   2 After 1: load byte @0x07 signed -> 0xFFFF_FF87; unsigned -> 0x0000_0087; half @0x04
//     signed -> 0x0000_4321.
//   3 Store byte 0xAA @0x05 over word 1 -> load word @0x04 = 0x8765_AA21 (other lanes kept).
//   4 LATENCY=3, req_i held high continuously -> accepts every 4 cycles, ready_o low 3 cycles,
//     exactly one valid_o per accept.
//   5 DMEM_ERR_EN: store word @0x06 -> err_o=1, memory unchanged; load @0x20 (DEPTH_WORDS=8)
//     -> err_o=1, data_o=0. Without macro: load word @0x06 returns word @0x04.
//   6 rst_i asserted during BUSY of a store -> no valid_o, target word unchanged, ready_o=1 next.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data-memory controller: access sizes, FSM states, lane masks.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Lane masks before shifting to the addressed lane
    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and data replication,
// load lane extraction with sign/zero extension (little endian).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_word,
    output logic [3:0]  byte_en,
    output logic [31:0] write_word,
    output logic [31:0] load_data
);

    logic [1:0]  eff_lane;
    logic [31:0] shifted;

    // Half drops addr[0] and word/reserved drop addr[1:0]; misalignment is flagged elsewhere
    always_comb begin
        eff_lane   = 2'b00;
        byte_en    = LANES_WORD;
        write_word = store_data;
        case (size)
            SZ_BYTE: begin
                eff_lane   = lane;
                byte_en    = LANES_BYTE << lane;
                write_word = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                eff_lane   = {lane[1], 1'b0};
                byte_en    = LANES_HALF << {lane[1], 1'b0};
                write_word = {2{store_data[15:0]}};
            end
            default: begin
                eff_lane   = 2'b00;
                byte_en    = LANES_WORD;
                write_word = store_data;
            end
        endcase
    end

    assign shifted = mem_word >> {eff_lane, 3'b000};

    always_comb begin
        load_data = shifted;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Data memory with req/valid handshake, programmable latency and sized accesses.
// Define DMEM_ERR_EN to flag misaligned, reserved-size and out-of-range accesses on err_o.
module dmem_sized_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 8,
    parameter int ADDR_W      = 32,
    parameter int LATENCY     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [31:0]       data_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              accept, exec, acc_err;
    logic              we_q, unsigned_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              valid_q, err_q;
    logic [31:0]       data_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic [3:0]        byte_en;
    logic [31:0]       write_word, load_data;

    assign accept = req_i && (state == ST_IDLE);
    assign exec   = (state == ST_BUSY) && (cnt == '0);
    assign idx    = addr_q[IDX_W+1:2];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (exec)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef DMEM_ERR_EN
    always_comb begin
        acc_err = 1'b0;
        if (size_q == SZ_RSVD)                      acc_err = 1'b1;
        if (size_q == SZ_HALF && addr_q[0])         acc_err = 1'b1;
        if (size_q == SZ_WORD && addr_q[1:0] != '0) acc_err = 1'b1;
        if (addr_q >= ADDR_W'(4 * DEPTH_WORDS))     acc_err = 1'b1;
    end
`else
    // Address bits above the array simply wrap
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[ADDR_W-1:IDX_W+2];
    assign acc_err = 1'b0;
`endif

    dmem_lane_align u_align (
        .size        (size_q),
        .is_unsigned (unsigned_q),
        .lane        (addr_q[1:0]),
        .store_data  (wdata_q),
        .mem_word    (mem[idx]),
        .byte_en     (byte_en),
        .write_word  (write_word),
        .load_data   (load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= exec;
            if (accept) begin
                cnt <= CNT_LOAD;
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec) begin
                err_q <= acc_err;
                if (!we_q) data_q <= acc_err ? 32'h0 : load_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q       <= we_i;
            size_q     <= size_i;
            unsigned_q <= unsigned_i;
            addr_q     <= addr_i;
            wdata_q    <= data_i;
        end
    end

    // A reset landing on the execute edge must discard the pending store
    always_ff @(posedge clk_i) begin
        if (exec && we_q && !acc_err && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[idx][8*i +: 8] <= write_word[8*i +: 8];
            end
        end
    end

    assign ready_o = (state == ST_IDLE);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule
